// File: rtl/cmplx_ram_reader_pkg.sv
// Shared spectrum-analyzer definitions: reader FSM encoding and pair FIFO sizing.
package cmplx_ram_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  localparam int FIFO_DEPTH = 4;
  // Wide enough to hold 0..FIFO_DEPTH for both occupancy and read credit.
  localparam int CREDIT_W   = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/cmplx_pair_fifo.sv
// Small FIFO holding {real_a, img_a, real_b, img_b} read pairs. The head entry is
// presented combinationally. The reader's credit scheme guarantees push never
// hits a full FIFO and pop never hits an empty one.
module cmplx_pair_fifo
  import cmplx_ram_reader_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic [WIDTH-1:0]    head,
  output logic [CREDIT_W-1:0] count,
  output logic                empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage: written on push, no reset needed since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CREDIT_W'(push) - CREDIT_W'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/cmplx_ram_reader.sv
// Streams a frame of complex bins out of a dual-port RAM. Even/odd bins are read
// as a pair per cycle, buffered in a pair FIFO under credit flow control, and
// serialized as one word per accepted handshake.
//
// state    | meaning
// IDLE     | waiting for start; base address sampled on start
// ISSUE    | issuing read pairs whenever credit is available
// DRAIN    | all pairs issued; waiting for the last word to be accepted
module cmplx_ram_reader
  import cmplx_ram_reader_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int N_POINTS = 1024,
  parameter int RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] address_a_out,
  output logic [ADDR_W-1:0] address_b_out,
  output logic              wren,
  input  logic [DATA_W-1:0] qreal_a,
  input  logic [DATA_W-1:0] qimg_a,
  input  logic [DATA_W-1:0] qreal_b,
  input  logic [DATA_W-1:0] qimg_b,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_img,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(N_POINTS / 2 - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_POINTS - 1);
  localparam int                PAIR_W    = 4 * DATA_W;

  rd_state_t             state, state_next;
  logic                  issue;
  logic                  handshake;
  logic                  last_word;
  logic                  sel_b;
  logic [ADDR_W-1:0]     pair_k;
  logic [RD_LAT-1:0]     vld_pipe;
  logic [CREDIT_W-1:0]   credit;
  logic [CREDIT_W-1:0]   fifo_count;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [PAIR_W-1:0]     fifo_head;

  // Credit covers both buffered pairs and pairs still inside the RAM pipeline,
  // so a pair emerging from the RAM always has a free FIFO slot.
  assign credit    = CREDIT_W'(FIFO_DEPTH - int'(fifo_count) - $countones(vld_pipe));
  assign out_valid = ~fifo_empty;
  assign handshake = out_valid & out_ready;
  assign last_word = (out_index == LAST_IDX);
  assign out_last  = out_valid & last_word;
  assign fifo_pop  = handshake & sel_b;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_ISSUE;
      ST_ISSUE: if (issue && pair_k == LAST_PAIR) state_next = ST_DRAIN;
      ST_DRAIN: if (handshake && last_word) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    issue = 1'b0;
    busy  = 1'b0;
    wren  = 1'b0;
    if (state == ST_ISSUE && credit != '0) issue = 1'b1;
    if (state != ST_IDLE) busy = 1'b1;
  end

  // Address generation, pair/word counters and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      address_a_out <= '0;
      address_b_out <= '0;
      pair_k        <= '0;
      out_index     <= '0;
      sel_b         <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= (state == ST_DRAIN) && handshake && last_word;
      if (state == ST_IDLE && start) begin
        address_a_out <= base_addr;
        address_b_out <= base_addr + ADDR_W'(1);
        pair_k        <= '0;
        out_index     <= '0;
        sel_b         <= 1'b0;
      end else begin
        if (issue) begin
          address_a_out <= address_a_out + ADDR_W'(2);
          address_b_out <= address_b_out + ADDR_W'(2);
          pair_k        <= pair_k + ADDR_W'(1);
        end
        if (handshake) begin
          out_index <= out_index + ADDR_W'(1);
          sel_b     <= ~sel_b;
        end
      end
    end
  end

  // Pair-valid flag follows the RAM read latency; reset discards in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  cmplx_pair_fifo #(
    .WIDTH (PAIR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_pipe[RD_LAT-1]),
    .push_data ({qreal_a, qimg_a, qreal_b, qimg_b}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign out_real = sel_b ? fifo_head[1*DATA_W +: DATA_W] : fifo_head[3*DATA_W +: DATA_W];
  assign out_img  = sel_b ? fifo_head[0*DATA_W +: DATA_W] : fifo_head[2*DATA_W +: DATA_W];

endmodule

// File: tb/tb_cmplx_ram_reader.sv
// Bench for cmplx_ram_reader: a 1024-point instance for streaming, backpressure,
// restart and reset scenarios, and an 8-point instance for address wrap-around.
// RAM contents encode the address, so each streamed word reveals which RAM
// location it came from.
module tb_cmplx_ram_reader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int N      = 1024;
  localparam int N8     = 8;
  localparam int RD_LAT = 2;
  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] seed = 32'h1234_5678;

  // Main 1024-point instance.
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic              wren;
  logic [DATA_W-1:0] qreal_a, qimg_a, qreal_b, qimg_b;
  logic [DATA_W-1:0] out_real, out_img;
  logic [ADDR_W-1:0] out_index;
  logic              out_valid, out_last, busy, done;
  logic              out_ready = 1'b0;

  cmplx_ram_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_POINTS(N), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .address_a_out(addr_a), .address_b_out(addr_b), .wren(wren),
    .qreal_a(qreal_a), .qimg_a(qimg_a), .qreal_b(qreal_b), .qimg_b(qimg_b),
    .out_real(out_real), .out_img(out_img), .out_index(out_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  // Small 8-point instance.
  logic              w_start = 1'b0;
  logic [ADDR_W-1:0] w_base = '0;
  logic [ADDR_W-1:0] w_addr_a, w_addr_b;
  logic              w_wren;
  logic [DATA_W-1:0] w_qreal_a, w_qimg_a, w_qreal_b, w_qimg_b;
  logic [DATA_W-1:0] w_real, w_img;
  logic [ADDR_W-1:0] w_index;
  logic              w_valid, w_last, w_busy, w_done;
  logic              w_ready = 1'b0;

  cmplx_ram_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_POINTS(N8), .RD_LAT(RD_LAT)
  ) dut8 (
    .clk(clk), .rst(rst), .start(w_start), .base_addr(w_base),
    .address_a_out(w_addr_a), .address_b_out(w_addr_b), .wren(w_wren),
    .qreal_a(w_qreal_a), .qimg_a(w_qimg_a), .qreal_b(w_qreal_b), .qimg_b(w_qimg_b),
    .out_real(w_real), .out_img(w_img), .out_index(w_index),
    .out_valid(w_valid), .out_ready(w_ready), .out_last(w_last),
    .busy(w_busy), .done(w_done)
  );

  // RAM models: data at address x is {seed[21:0], x} / {x, ~seed[21:0]},
  // returned RD_LAT cycles after the address is presented.
  logic [ADDR_W-1:0] pa [RD_LAT];
  logic [ADDR_W-1:0] pb [RD_LAT];
  logic [ADDR_W-1:0] wpa [RD_LAT];
  logic [ADDR_W-1:0] wpb [RD_LAT];

  always @(posedge clk) begin
    pa[0] <= addr_a;   pb[0] <= addr_b;
    wpa[0] <= w_addr_a; wpb[0] <= w_addr_b;
    for (int i = 1; i < RD_LAT; i++) begin
      pa[i] <= pa[i-1];   pb[i] <= pb[i-1];
      wpa[i] <= wpa[i-1]; wpb[i] <= wpb[i-1];
    end
  end

  assign qreal_a   = {seed[21:0], pa[RD_LAT-1]};
  assign qimg_a    = {pa[RD_LAT-1], ~seed[21:0]};
  assign qreal_b   = {seed[21:0], pb[RD_LAT-1]};
  assign qimg_b    = {pb[RD_LAT-1], ~seed[21:0]};
  assign w_qreal_a = {seed[21:0], wpa[RD_LAT-1]};
  assign w_qimg_a  = {wpa[RD_LAT-1], ~seed[21:0]};
  assign w_qreal_b = {seed[21:0], wpb[RD_LAT-1]};
  assign w_qimg_b  = {wpb[RD_LAT-1], ~seed[21:0]};

  // Continuous monitors: write enable never asserted, credit never out of range.
  always @(negedge clk) begin
    n_cmp++;
    if (wren !== 1'b0 || w_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL wren: got %b/%b required 0/0 at %0t", wren, w_wren, $time);
    end
    n_cmp++;
    if (dut.credit > 3'd4 || dut8.credit > 3'd4) begin
      n_fail++;
      $display("FAIL credit_range: got %0d/%0d required 0..4 at %0t", dut.credit, dut8.credit, $time);
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        out_index !== '0 || addr_a !== '0 || addr_b !== '0 || dut.credit !== 3'd4) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b last=%b busy=%b done=%b idx=%0d a=%0d b=%0d credit=%0d required 0,0,0,0,0,0,0,4",
               out_valid, out_last, busy, done, out_index, addr_a, addr_b, dut.credit);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || w_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b valid=%b w_busy=%b required 0", busy, out_valid, w_busy);
    end
  endtask

  // Runs one frame on the main instance and checks every word against the
  // address-derived model. restart_at >= 0 pulses start at that cycle;
  // rst_at >= 0 asserts reset once that many words have been accepted.
  task automatic run_frame(input int base, input int pct, input int restart_at,
                           input int rst_at, input bit check_lat, input string tag);
    int widx = 0;
    int c = 0;
    bit fin = 1'b0;
    bit stalled = 1'b0;
    bit last_hs = 1'b0;
    bit first_seen = 1'b0;
    logic [DATA_W-1:0] pr, pim;
    logic [ADDR_W-1:0] pidx, ea;
    logic plast;
    seed = $urandom;
    @(negedge clk);
    base_addr = ADDR_W'(base);
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!fin && c < BUDGET) begin
      if (last_hs) begin
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s done_pulse: done=%b busy=%b required done=1 busy=0", tag, done, busy);
        end
        fin = 1'b1;
      end else begin
        n_cmp++;
        if (done !== 1'b0) begin
          n_fail++;
          $display("FAIL %s early_done: done=%b required 0 at word %0d", tag, done, widx);
        end
        if (check_lat && !first_seen && out_valid === 1'b1) begin
          n_cmp++;
          if (c != RD_LAT + 1) begin
            n_fail++;
            $display("FAIL %s first_valid: cycle %0d required %0d", tag, c, RD_LAT + 1);
          end
        end
        if (check_lat && first_seen) begin
          n_cmp++;
          if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s throughput: valid=%b required 1 at word %0d", tag, out_valid, widx);
          end
        end
        if (out_valid === 1'b1) first_seen = 1'b1;
        if (stalled) begin
          n_cmp++;
          if (out_valid !== 1'b1 || out_real !== pr || out_img !== pim ||
              out_index !== pidx || out_last !== plast) begin
            n_fail++;
            $display("FAIL %s stall_stable: valid=%b real=%h img=%h idx=%0d last=%b required 1 %h %h %0d %b",
                     tag, out_valid, out_real, out_img, out_index, out_last, pr, pim, pidx, plast);
          end
        end
        if (out_valid === 1'b1) begin
          ea = ADDR_W'(base + widx);
          n_cmp++;
          if (widx >= N || out_index !== ADDR_W'(widx) || out_real !== {seed[21:0], ea} ||
              out_img !== {ea, ~seed[21:0]} || out_last !== (widx == N - 1)) begin
            n_fail++;
            $display("FAIL %s word: idx=%0d real=%h img=%h last=%b required idx=%0d real=%h img=%h last=%b",
                     tag, out_index, out_real, out_img, out_last, widx,
                     {seed[21:0], ea}, {ea, ~seed[21:0]}, (widx == N - 1));
          end
        end
        out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
        stalled = (out_valid === 1'b1) && !out_ready;
        pr = out_real; pim = out_img; pidx = out_index; plast = out_last;
        if (out_valid === 1'b1 && out_ready) begin
          if (widx == N - 1) last_hs = 1'b1;
          widx++;
        end
        if (c == restart_at) begin
          start = 1'b1;
          base_addr = ADDR_W'($urandom);
        end else begin
          start = 1'b0;
        end
        if (rst_at >= 0 && widx >= rst_at) begin
          rst = 1'b1;
          start = 1'b0;
          out_ready = 1'b0;
          @(negedge clk);
          n_cmp++;
          if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
              out_index !== '0 || addr_a !== '0 || addr_b !== '0 || dut.credit !== 3'd4) begin
            n_fail++;
            $display("FAIL %s mid_reset: valid=%b last=%b busy=%b done=%b idx=%0d a=%0d b=%0d credit=%0d required 0,0,0,0,0,0,0,4",
                     tag, out_valid, out_last, busy, done, out_index, addr_a, addr_b, dut.credit);
          end
          rst = 1'b0;
          repeat (10) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
              n_fail++;
              $display("FAIL %s after_reset: done=%b valid=%b busy=%b required 0", tag, done, out_valid, busy);
            end
          end
          return;
        end
        c++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s timeout: words=%0d required %0d within %0d cycles", tag, widx, N, BUDGET);
    end else begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || widx != N) begin
        n_fail++;
        $display("FAIL %s post_frame: done=%b busy=%b valid=%b words=%0d required 0,0,0,%0d",
                 tag, done, busy, out_valid, widx, N);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_frame;
    run_frame(0, 100, -1, -1, 1'b1, "full_frame");
  endtask

  task automatic test_backpressure;
    run_frame(int'($urandom_range(0, 1023)), 30, -1, -1, 1'b0, "backpressure");
  endtask

  task automatic test_restart_ignored;
    run_frame(int'($urandom_range(0, 1023)), 100, 100, -1, 1'b1, "restart_ignored");
  endtask

  task automatic test_reset_mid_frame;
    run_frame(64, 100, -1, 500, 1'b0, "reset_mid");
    run_frame(int'($urandom_range(0, 1023)), 100, -1, -1, 1'b1, "after_reset_frame");
  endtask

  task automatic test_wrap;
    int widx = 0;
    int c = 0;
    bit got_done = 1'b0;
    logic [ADDR_W-1:0] ea;
    seed = $urandom;
    @(negedge clk);
    w_base = 10'd1020;
    w_start = 1'b1;
    w_ready = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    while (!got_done && c < 200) begin
      if (w_busy === 1'b1) begin
        n_cmp++;
        if (w_addr_b !== ADDR_W'(w_addr_a + 10'd1)) begin
          n_fail++;
          $display("FAIL wrap addr_pair: a=%0d b=%0d required b=a+1 mod 1024", w_addr_a, w_addr_b);
        end
      end
      if (w_valid === 1'b1) begin
        ea = ADDR_W'(1020 + widx);
        n_cmp++;
        if (widx >= N8 || w_index !== ADDR_W'(widx) || w_real !== {seed[21:0], ea} ||
            w_img !== {ea, ~seed[21:0]} || w_last !== (widx == N8 - 1)) begin
          n_fail++;
          $display("FAIL wrap word: idx=%0d ram_addr=%0d last=%b required idx=%0d ram_addr=%0d last=%b",
                   w_index, w_real[9:0], w_last, widx, ea, (widx == N8 - 1));
        end
        widx++;
      end
      if (w_done === 1'b1) got_done = 1'b1;
      c++;
      @(negedge clk);
    end
    w_ready = 1'b0;
    n_cmp++;
    if (!got_done || widx != N8) begin
      n_fail++;
      $display("FAIL wrap completion: done_seen=%b words=%0d required 1 and %0d", got_done, widx, N8);
    end
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_backpressure;
    test_restart_ignored;
    test_reset_mid_frame;
    test_wrap;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cmplx_ram_reader.md
CMPLX_RAM_READER -- requirements
Module: cmplx_ram_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 32, width of each real/imag word.
REQ-003 SHALL have parameter N_POINTS, default 1024, number of bins per frame (even, <= 2^ADDR_W).
REQ-004 SHALL have parameter RD_LAT, default 2, cycles from address to valid q on the RAM.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame read.
- base_addr  in  ADDR_W  first bin address, sampled on start.
- address_a_out  out  ADDR_W  RAM port A address (even offsets).
- address_b_out  out  ADDR_W  RAM port B address (odd offsets).
- wren  out  1  RAM write enable, constant 0.
- qreal_a / qimg_a / qreal_b / qimg_b  in  DATA_W each  RAM read data.
- out_real / out_img  out  DATA_W each  streamed bin value.
- out_index  out  ADDR_W  bin offset 0..N_POINTS-1.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts when out_valid and out_ready are both high.
- out_last  out  1  high with the word at offset N_POINTS-1.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last word is accepted.

Function
REQ-006 SHALL use FSM states IDLE, ISSUE, DRAIN; IDLE->ISSUE on start; ISSUE->DRAIN after the last pair is issued; DRAIN->IDLE when the last word is accepted.
REQ-007 SHALL ignore start while busy is high.
REQ-008 SHALL issue a read pair per cycle in ISSUE, address_a_out = base+2k and address_b_out = base+2k+1, k = 0..N_POINTS/2-1, only when credit > 0.
REQ-009 SHALL compute addresses modulo 2^ADDR_W, so reads wrap past the top of memory.
REQ-010 SHALL delay a pair-valid flag through an RD_LAT-stage shift register and capture {qreal_a,qimg_a,qreal_b,qimg_b} into a 4-entry pair FIFO when the flag emerges.
REQ-011 SHALL maintain credit = 4 - FIFO occupancy - pairs in flight; credit SHALL never go negative and the FIFO SHALL never overflow.
REQ-012 SHALL serialize each FIFO pair as port A word then port B word, one word per accepted handshake.
REQ-013 SHALL hold out_real, out_img, out_index and out_last stable while out_valid is high and out_ready is low.
REQ-014 SHALL assert out_valid whenever a word is available, independent of out_ready.
REQ-015 SHALL pulse done the cycle after the last handshake, deassert busy in that same cycle, and allow a start in that cycle or later.
REQ-016 SHALL sustain 1 word/cycle with out_ready held high; first out_valid SHALL occur RD_LAT+1 cycles after start.
REQ-017 SHALL tie wren to 0 in every cycle.

Reset
REQ-018 SHALL, on rst, enter IDLE and clear out_valid, out_last, busy, done, the FIFO, the in-flight flags, the addresses and out_index to 0, and set credit to 4.
REQ-019 SHALL abort a frame when rst is asserted mid-frame, without emitting done, and discard in-flight RAM data.

Structure
REQ-020 SHALL place the FSM state encoding and FIFO depth constant (4) in the shared spectrum analyzer package.
REQ-021 SHALL implement the pair FIFO as the sub-module cmplx_pair_fifo.

Verification
REQ-022 Bench SHALL cover: base=0, N=1024, out_ready=1 -> 1024 words, indices 0..1023 in order, first valid at cycle RD_LAT+1, out_last on index 1023, done one cycle later.
REQ-023 Bench SHALL cover: base=1020, N=8 -> RAM addresses 1020..1023,0..3, with out_index 0..7.
REQ-024 Bench SHALL cover: out_ready random at 30% -> no lost or duplicate word, data stable while stalled, credit always in 0..4.
REQ-025 Bench SHALL cover: start pulsed again mid-frame -> ignored, word count stays 1024.
REQ-026 Bench SHALL cover: rst at word 500 -> outputs cleared the next cycle, no done, and a new start completes a full frame correctly.
REQ-027 Bench SHALL cover: wren monitored over a full run -> 0 in every cycle.
